// File: rtl/instr_encoder_loader.sv
//==============================================================================
// Module   : instr_encoder_loader
// Desc     : Packs symbolic instruction fields into 16-bit words, buffers them
//            in a FIFO and writes them to instruction memory through a
//            waitrequest-style write master. Optional macro: ENC_IMM_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_encoder_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int ADDR_STEP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rx,
    input  logic [2:0]        in_ry,
    input  logic [10:0]       in_imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wrdata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] words_written
`ifdef ENC_IMM_CHECK_EN
    ,
    output logic              err_imm
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d, words_q, words_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_ill_q, err_ill_d;

    logic [15:0] enc_word;
    logic        op_legal;
    logic        imm_ok;
    logic        fifo_full, fifo_empty;
    logic        accept, push, pop, commit;

    always_comb begin
        enc_word = 16'h0000;
        case (in_op[4:3])
            2'b00:   enc_word = {5'b00000, in_ry, in_rx, in_op};
            2'b10:   enc_word = {in_imm[7:0], in_rx, in_op};
            2'b01:   enc_word = {8'h00, in_rx, in_op};
            default: enc_word = {in_imm[10:0], in_op};
        endcase
    end

    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
            5'b01000, 5'b01001, 5'b01010, 5'b01100,
            5'b11000, 5'b11001, 5'b11010, 5'b11100: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    // imm8 forms must not lose information; mvhi takes an unsigned byte
    always_comb begin
        imm_ok = 1'b1;
        if (in_op[4:3] == 2'b10) begin
            if (in_op == 5'b10110)
                imm_ok = (in_imm[10:8] == 3'b000);
            else
                imm_ok = (in_imm[10:8] == {3{in_imm[7]}});
        end
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (state_q == S_RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && op_legal && imm_ok;
    assign pop        = !fifo_empty && !write_q;
    assign commit     = write_q && !mem_waitrequest;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        err_ill_d = err_ill_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    addr_d    = base_addr;
                    words_d   = '0;
                    err_ill_d = 1'b0;
                end
            end
            S_RUN:   if (finish) state_d = S_FLUSH;
            S_FLUSH: if (fifo_empty && !write_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            write_d = 1'b0;
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            words_d = words_q + 1'b1;
        end
        if (pop) begin
            wdata_d  = fifo_q[rd_ptr_q];
            write_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (accept && !op_legal) err_ill_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_ill_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_ill_q <= err_ill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= enc_word;
    end

`ifdef ENC_IMM_CHECK_EN
    logic err_imm_q;
    always_ff @(posedge clk) begin
        if (reset)
            err_imm_q <= 1'b0;
        else if (state_q == S_IDLE && start)
            err_imm_q <= 1'b0;
        else if (accept && op_legal && !imm_ok)
            err_imm_q <= 1'b1;
    end
    assign err_imm = err_imm_q;
`endif

    assign mem_addr      = addr_q;
    assign mem_wrdata    = wdata_q;
    assign mem_write     = write_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done          = (state_q == S_DONE);
    assign err_illegal   = err_ill_q;
    assign words_written = words_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
//==============================================================================
// Module   : tb_instr_encoder_loader
// Desc     : Directed-vector bench with a write scoreboard for
//            instr_encoder_loader.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid, in_ready;
    logic [15:0] base_addr;
    logic [4:0]  in_op;
    logic [2:0]  in_rx, in_ry;
    logic [10:0] in_imm;
    logic [15:0] mem_addr, mem_wrdata, words_written;
    logic        mem_write, mem_waitrequest, busy, done, err_illegal;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    logic [15:0] exp_addr;
    int          n_accepts;
    int          accepts_at_stall;
    bit          stall_seen;

    always #5 clk = ~clk;

    instr_encoder_loader #(.FIFO_DEPTH(4), .ADDR_W(16), .ADDR_STEP(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest), .busy(busy), .done(done),
        .err_illegal(err_illegal), .words_written(words_written)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every committed write must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && mem_write && !mem_waitrequest) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h@%h required=none", mem_wrdata, mem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {mem_addr, mem_wrdata}, mon_e);
            end
        end
    end

    task automatic do_start(input logic [15:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = b;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [10:0] imm, input logic [15:0] word, input bit legal);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op = op; in_rx = rx; in_ry = ry; in_imm = imm;
        if (legal) begin
            exp_q.push_back({exp_addr, word});
            exp_addr = exp_addr + 16'd2;
        end
        @(negedge clk);
        if (!in_ready && !stall_seen) begin
            stall_seen = 1'b1;
            accepts_at_stall = n_accepts;
        end
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        n_accepts++;
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_session(input int words, input logic err);
        int n;
        n = 0;
        finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        @(negedge clk);
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("words_written", {16'd0, words_written}, words);
        check("err_illegal", {31'd0, err_illegal}, {31'd0, err});
        check("queue_drained", exp_q.size(), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] stream_words [8] = '{16'h1010, 16'h1130, 16'h1250, 16'h1370,
                                      16'h1490, 16'h15B0, 16'h16D0, 16'h17F0};

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        base_addr = '0; in_op = '0; in_rx = '0; in_ry = '0; in_imm = '0;
        mem_waitrequest = 1'b0; exp_addr = '0;
        n_accepts = 0; accepts_at_stall = -1; stall_seen = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wrdata", {16'd0, mem_wrdata}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_err_words", {15'd0, err_illegal, words_written}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // add r1,r2
        do_start(16'h0000);
        send(5'b00001, 3'd1, 3'd2, 11'h000, 16'h0221, 1'b1);
        finish_session(1, 1'b0);

        // mvi r3,0x5A ; jr r7 ; j 0x004
        do_start(16'h0000);
        send(5'b10000, 3'd3, 3'd0, 11'h05A, 16'h5A70, 1'b1);
        send(5'b01000, 3'd7, 3'd0, 11'h000, 16'h00E8, 1'b1);
        send(5'b11000, 3'd0, 3'd0, 11'h004, 16'h0098, 1'b1);
        finish_session(3, 1'b0);

        // Stream 8 words against a stalled memory
        do_start(16'h0000);
        mem_waitrequest = 1'b1;
        stall_seen = 1'b0;
        n_accepts = 0;
        fork
            begin
                repeat (8) @(posedge clk);
                #1 mem_waitrequest = 1'b0;
            end
        join_none
        for (int i = 0; i < 8; i++)
            send(5'b10000, 3'(i), 3'd0, 11'(16 + i), stream_words[i], 1'b1);
        check("accepts_before_stall", accepts_at_stall, 32'd5);
        finish_session(8, 1'b0);

        // Illegal opcode between two legal words
        do_start(16'h0000);
        send(5'b00001, 3'd1, 3'd2, 11'h000, 16'h0221, 1'b1);
        send(5'b00110, 3'd1, 3'd1, 11'h000, 16'h0000, 1'b0);
        send(5'b01000, 3'd7, 3'd0, 11'h000, 16'h00E8, 1'b1);
        finish_session(2, 1'b1);
        do_start(16'h0000);
        @(negedge clk);
        check("err_cleared_on_start", {31'd0, err_illegal}, 32'd0);
        @(posedge clk);
        #1;
        finish_session(0, 1'b0);

        // Address wrap
        do_start(16'hFFFE);
        send(5'b00001, 3'd1, 3'd2, 11'h000, 16'h0221, 1'b1);
        send(5'b01000, 3'd7, 3'd0, 11'h000, 16'h00E8, 1'b1);
        finish_session(2, 1'b0);

        // Reset during FLUSH with a stalled write
        do_start(16'h0000);
        mem_waitrequest = 1'b1;
        send(5'b00001, 3'd1, 3'd2, 11'h000, 16'h0221, 1'b1);
        send(5'b01000, 3'd7, 3'd0, 11'h000, 16'h00E8, 1'b1);
        finish = 1'b1;
        @(posedge clk);
        #1 finish = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mem_waitrequest = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_words", {16'd0, words_written}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_stale_write", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        do_start(16'h0100);
        send(5'b10000, 3'd0, 3'd0, 11'h010, 16'h1010, 1'b1);
        finish_session(1, 1'b0);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
